// File: rtl/adc_align_pkg.sv
// Shared types and constants for the ADC lane link-training controller.
package adc_align_pkg;

  localparam int TAP_W     = 5;
  localparam int LANE_W    = 6;
  localparam int MAX_SLIPS = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DRST,
    ST_SETTLE,
    ST_SCAN,
    ST_CHECK,
    ST_STEP,
    ST_SLIP,
    ST_NEXT,
    ST_FAIL
  } state_t;

  function automatic logic [LANE_W-1:0] lane_sel(input logic [2*LANE_W-1:0] w, input logic lane);
    return lane ? w[2*LANE_W-1:LANE_W] : w[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/lane_eye_tracker.sv
// Tracks the current stable-tap run and the longest one seen so far; ties keep the earlier run.
// Result is registered: best_* reflect an update one cycle after upd.
module lane_eye_tracker
  import adc_align_pkg::*;
(
  input  logic             lclk,
  input  logic             rst,
  input  logic             clear,
  input  logic             upd,
  input  logic             stable,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len
);

  logic [TAP_W-1:0] run_start;
  logic [TAP_W:0]   run_len;
  logic [TAP_W:0]   run_inc;
  logic [TAP_W-1:0] run_start_cur;

  assign run_inc       = run_len + 1'b1;
  assign run_start_cur = (run_len == '0) ? tap : run_start;

  // Best is refreshed as the run grows, so a run ending at tap 31 needs no extra close step.
  always_ff @(posedge lclk) begin
    if (rst || clear) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (upd) begin
      if (stable) begin
        run_len   <= run_inc;
        run_start <= run_start_cur;
        if (run_inc > best_len) begin
          best_len   <= run_inc;
          best_start <= run_start_cur;
        end
      end else begin
        run_len <= '0;
      end
    end
  end

endmodule

// File: rtl/adc_lane_aligner.sv
// Per-lane eye sweep, tap centring and bitslip word alignment for a two-lane ADC channel.
// All outputs registered; ADC_ALIGN_DBG_EN adds eye/centre debug outputs.
module adc_lane_aligner
  import adc_align_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLES       = 8,
  parameter int MIN_EYE       = 4
) (
  input  logic                lclk,
  input  logic                rst,
  input  logic                start,
  input  logic [2*LANE_W-1:0] adc_bits,
  input  logic [2*LANE_W-1:0] train_pattern,
  output logic [1:0]          in_delay_reset,
  output logic [1:0]          in_delay_data_ce,
  output logic [1:0]          in_delay_data_inc,
  output logic [1:0]          adc_bitslip,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                err_lane
`ifdef ADC_ALIGN_DBG_EN
  ,
  output logic [TAP_W-1:0]    eye_start_0,
  output logic [TAP_W-1:0]    eye_start_1,
  output logic [TAP_W:0]      eye_len_0,
  output logic [TAP_W:0]      eye_len_1,
  output logic [TAP_W-1:0]    tap_center_0,
  output logic [TAP_W-1:0]    tap_center_1
`endif
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SMP_W = $clog2(SAMPLES + 1);
  localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_W-1:0] SMP_LAST   = SMP_W'(SAMPLES - 1);
  localparam logic [TAP_W:0]   MIN_LEN    = (TAP_W + 1)'(MIN_EYE);
  localparam logic [TAP_W-1:0] TAP_MAX    = '1;
  localparam logic [2:0]       SLIP_LIMIT = 3'(MAX_SLIPS);

  state_t state_q, state_d, ret_q, ret_d;
  logic              lane_q, lane_d;
  logic [TAP_W-1:0]  tap_q, tap_d, center_q, center_d;
  logic [2:0]        slip_q, slip_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic [SMP_W-1:0]  smp_q, smp_d;
  logic [LANE_W-1:0] ref_q, ref_d;
  logic              mis_q, mis_d;
  logic [1:0]        dly_rst_d, ce_d, bitslip_d;
  logic              busy_d, done_d, error_d, err_lane_d;

  logic [LANE_W-1:0] word, pat;
  logic [1:0]        lane_oh;
  logic              stable, trk_upd;
  logic [TAP_W-1:0]  best_start, ctr_calc;
  logic [TAP_W:0]    best_len;

  assign word     = lane_sel(adc_bits, lane_q);
  assign pat      = lane_sel(train_pattern, lane_q);
  assign lane_oh  = lane_q ? 2'b10 : 2'b01;
  assign stable   = (smp_q == '0) || (!mis_q && (word == ref_q));
  assign trk_upd  = (state_q == ST_SCAN) && (smp_q == SMP_LAST);
  assign ctr_calc = best_start + best_len[TAP_W:1];

  lane_eye_tracker u_trk (
    .lclk       (lclk),
    .rst        (rst),
    .clear      (state_q == ST_DRST),
    .upd        (trk_upd),
    .stable     (stable),
    .tap        (tap_q),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    lane_d     = lane_q;
    tap_d      = tap_q;
    center_d   = center_q;
    slip_d     = slip_q;
    set_d      = set_q;
    smp_d      = smp_q;
    ref_d      = ref_q;
    mis_d      = mis_q;
    dly_rst_d  = '0;
    ce_d       = '0;
    bitslip_d  = '0;
    busy_d     = busy;
    done_d     = done;
    error_d    = error;
    err_lane_d = err_lane;
    case (state_q)
      ST_IDLE: if (start) begin
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_lane_d = 1'b0;
        busy_d     = 1'b1;
        lane_d     = 1'b0;
        state_d    = ST_DRST;
      end
      ST_DRST: begin
        dly_rst_d = lane_oh;
        tap_d     = '0;
        set_d     = '0;
        ret_d     = ST_SCAN;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        smp_d = '0;
        mis_d = 1'b0;
        if (set_q == SET_LAST) state_d = ret_q;
        else                   set_d   = set_q + 1'b1;
      end
      ST_SCAN: begin
        if (smp_q == '0)        ref_d = word;
        else if (word != ref_q) mis_d = 1'b1;
        smp_d = smp_q + 1'b1;
        if (smp_q == SMP_LAST) begin
          if (tap_q != TAP_MAX) begin
            ce_d    = lane_oh;
            tap_d   = tap_q + 1'b1;
            set_d   = '0;
            ret_d   = ST_SCAN;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (best_len < MIN_LEN) begin
          state_d = ST_FAIL;
        end else begin
          center_d  = ctr_calc;
          dly_rst_d = lane_oh;
          tap_d     = '0;
          set_d     = '0;
          ret_d     = ST_STEP;
          state_d   = ST_SETTLE;
        end
      end
      ST_STEP: begin
        if (tap_q != center_q) begin
          ce_d    = lane_oh;
          tap_d   = tap_q + 1'b1;
          set_d   = '0;
          ret_d   = ST_STEP;
          state_d = ST_SETTLE;
        end else begin
          slip_d  = '0;
          state_d = ST_SLIP;
        end
      end
      ST_SLIP: begin
        if (word == pat) begin
          state_d = ST_NEXT;
        end else if (slip_q == SLIP_LIMIT) begin
          state_d = ST_FAIL;
        end else begin
          bitslip_d = lane_oh;
          slip_d    = slip_q + 1'b1;
          set_d     = '0;
          ret_d     = ST_SLIP;
          state_d   = ST_SETTLE;
        end
      end
      ST_NEXT: begin
        if (!lane_q) begin
          lane_d  = 1'b1;
          state_d = ST_DRST;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_FAIL: begin
        error_d    = 1'b1;
        err_lane_d = lane_q;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge lclk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      ret_q             <= ST_IDLE;
      lane_q            <= 1'b0;
      tap_q             <= '0;
      center_q          <= '0;
      slip_q            <= '0;
      set_q             <= '0;
      smp_q             <= '0;
      ref_q             <= '0;
      mis_q             <= 1'b0;
      in_delay_reset    <= '0;
      in_delay_data_ce  <= '0;
      in_delay_data_inc <= '0;
      adc_bitslip       <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      err_lane          <= 1'b0;
    end else begin
      state_q           <= state_d;
      ret_q             <= ret_d;
      lane_q            <= lane_d;
      tap_q             <= tap_d;
      center_q          <= center_d;
      slip_q            <= slip_d;
      set_q             <= set_d;
      smp_q             <= smp_d;
      ref_q             <= ref_d;
      mis_q             <= mis_d;
      in_delay_reset    <= dly_rst_d;
      in_delay_data_ce  <= ce_d;
      in_delay_data_inc <= ce_d;
      adc_bitslip       <= bitslip_d;
      busy              <= busy_d;
      done              <= done_d;
      error             <= error_d;
      err_lane          <= err_lane_d;
    end
  end

`ifdef ADC_ALIGN_DBG_EN
  // Snapshot of the eye as judged in CHECK, kept even when the lane then fails.
  always_ff @(posedge lclk) begin
    if (rst) begin
      eye_start_0  <= '0;
      eye_start_1  <= '0;
      eye_len_0    <= '0;
      eye_len_1    <= '0;
      tap_center_0 <= '0;
      tap_center_1 <= '0;
    end else if (state_q == ST_CHECK) begin
      if (lane_q) begin
        eye_start_1  <= best_start;
        eye_len_1    <= best_len;
        tap_center_1 <= ctr_calc;
      end else begin
        eye_start_0  <= best_start;
        eye_len_0    <= best_len;
        tap_center_0 <= ctr_calc;
      end
    end
  end
`endif

endmodule
